// File: rtl/toaplan2_pcm_mixer.sv
// toaplan2_pcm_mixer: N-channel PCM mixer, one shared MAC per output sample,
// ramped 4.4 gains, saturating output and peak-hold clip indicator.
// Ports: CLK96/RESET96_N clock and async low reset; CEN sample strobe;
//   CH_DIN/CH_GAIN/CH_EN/MUTE channel inputs; MIXED/SAMPLE mixed output and
//   its valid pulse; PEAK clip-hold flag; BUSY while a sample is in flight.
// Optional: define MIXER_DC_BLOCK_EN to add a one-pole DC blocker ahead of
//   saturation.
module toaplan2_pcm_mixer #(
    parameter int NCH       = 4,
    parameter int IW        = 16,
    parameter int WOUT      = 16,
    parameter int PEAK_HOLD = 4096
) (
    input  logic                CLK96,
    input  logic                RESET96_N,
    input  logic                CEN,
    input  logic [NCH*IW-1:0]   CH_DIN,
    input  logic [NCH*8-1:0]    CH_GAIN,
    input  logic [NCH-1:0]      CH_EN,
    input  logic                MUTE,
    output logic [WOUT-1:0]     MIXED,
    output logic                SAMPLE,
    output logic                PEAK,
    output logic                BUSY
);

    localparam int CW  = $clog2(NCH);
    localparam int PW  = IW + 9;
    localparam int AW  = IW + 9 + CW;
    localparam int RW  = AW - 4;
    localparam int PCW = $clog2(PEAK_HOLD + 1);

    localparam logic signed [RW-1:0] MAX_V =
        {{(RW-WOUT+1){1'b0}}, {(WOUT-1){1'b1}}};
    localparam logic signed [RW-1:0] MIN_V =
        {{(RW-WOUT+1){1'b1}}, {(WOUT-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MAC, S_OUT} state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            idx_q, idx_d;
    logic [NCH-1:0][IW-1:0]   snap_q, snap_d;
    logic [NCH-1:0][7:0]      gain_q, gain_d;
    logic signed [AW-1:0]     acc_q, acc_d, acc_sum;
    logic [WOUT-1:0]          mixed_q, mixed_d;
    logic                     peak_q, peak_d;
    logic [PCW-1:0]           pcnt_q, pcnt_d;

    logic signed [PW-1:0]     prod;
    logic signed [RW-1:0]     r, sat_in;
    logic                     last, fin, clip_hi, clip_lo;
    logic [7:0]               tgt;

    // Signed sample times zero-extended unsigned gain.
    assign prod    = PW'($signed(snap_q[idx_q]))
                   * PW'($signed({1'b0, gain_q[idx_q]}));
    assign acc_sum = acc_q + AW'(prod);
    assign r       = RW'(acc_sum >>> 4);
    assign last    = (idx_q == CW'(NCH - 1));
    // The final MAC step also registers the result so SAMPLE and MIXED
    // become valid together in the OUT cycle.
    assign fin     = (state_q == S_MAC) && last;

`ifdef MIXER_DC_BLOCK_EN
    localparam int DW = IW + 6;
    logic signed [DW-1:0] r_prev_q, r_prev_d, y_prev_q, y_prev_d;
    logic signed [DW-1:0] r_dc, y_dc;

    always_comb begin
        r_dc     = DW'(r);
        y_dc     = r_dc - r_prev_q + y_prev_q - (y_prev_q >>> 8);
        sat_in   = RW'(y_dc);
        r_prev_d = fin ? r_dc : r_prev_q;
        y_prev_d = fin ? y_dc : y_prev_q;
    end

    always_ff @(posedge CLK96 or negedge RESET96_N) begin
        if (!RESET96_N) begin
            r_prev_q <= '0;
            y_prev_q <= '0;
        end else begin
            r_prev_q <= r_prev_d;
            y_prev_q <= y_prev_d;
        end
    end
`else
    assign sat_in = r;
`endif

    assign clip_hi = (sat_in > MAX_V);
    assign clip_lo = (sat_in < MIN_V);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        gain_d  = gain_q;
        acc_d   = acc_q;
        mixed_d = mixed_q;
        peak_d  = peak_q;
        pcnt_d  = pcnt_q;
        tgt     = '0;
        unique case (state_q)
            S_IDLE: begin
                if (CEN) state_d = S_LOAD;
            end
            S_LOAD: begin
                snap_d  = CH_DIN;
                acc_d   = '0;
                idx_d   = '0;
                state_d = S_MAC;
                // Anti-zipper: move one LSB per sample toward target.
                for (int k = 0; k < NCH; k++) begin
                    tgt = (MUTE || !CH_EN[k]) ? 8'h00 : CH_GAIN[k*8 +: 8];
                    if (gain_q[k] < tgt)
                        gain_d[k] = gain_q[k] + 8'd1;
                    else if (gain_q[k] > tgt)
                        gain_d[k] = gain_q[k] - 8'd1;
                end
            end
            S_MAC: begin
                acc_d = acc_sum;
                if (last) begin
                    state_d = S_OUT;
                    if (clip_hi)
                        mixed_d = {1'b0, {(WOUT-1){1'b1}}};
                    else if (clip_lo)
                        mixed_d = {1'b1, {(WOUT-1){1'b0}}};
                    else
                        mixed_d = sat_in[WOUT-1:0];
                    // PEAK holds while the counter from the last clip
                    // has not yet run out.
                    if (clip_hi || clip_lo) begin
                        peak_d = 1'b1;
                        pcnt_d = PCW'(PEAK_HOLD - 1);
                    end else begin
                        peak_d = (pcnt_q != '0);
                        if (pcnt_q != '0) pcnt_d = pcnt_q - PCW'(1);
                    end
                end else begin
                    idx_d = idx_q + CW'(1);
                end
            end
            S_OUT: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK96 or negedge RESET96_N) begin
        if (!RESET96_N) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            snap_q  <= '0;
            gain_q  <= '0;
            acc_q   <= '0;
            mixed_q <= '0;
            peak_q  <= 1'b0;
            pcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            gain_q  <= gain_d;
            acc_q   <= acc_d;
            mixed_q <= mixed_d;
            peak_q  <= peak_d;
            pcnt_q  <= pcnt_d;
        end
    end

    assign MIXED  = mixed_q;
    assign SAMPLE = (state_q == S_OUT);
    assign PEAK   = peak_q;
    assign BUSY   = (state_q != S_IDLE);

endmodule

// File: tb/tb_toaplan2_pcm_mixer.sv
// tb_toaplan2_pcm_mixer: randomized bench for toaplan2_pcm_mixer with an
// arithmetic reference model of gain ramp, mix, saturation and peak hold.
module tb_toaplan2_pcm_mixer;

    localparam int NCH  = 4;
    localparam int IW   = 16;
    localparam int WOUT = 16;
    localparam int PH   = 4096;

    logic                CLK96 = 1'b0;
    logic                RESET96_N;
    logic                CEN;
    logic [NCH*IW-1:0]   CH_DIN;
    logic [NCH*8-1:0]    CH_GAIN;
    logic [NCH-1:0]      CH_EN;
    logic                MUTE;
    logic [WOUT-1:0]     MIXED;
    logic                SAMPLE;
    logic                PEAK;
    logic                BUSY;

    int n_checks;
    int n_fail;
    int g_m[NCH];
    int since_clip;

    toaplan2_pcm_mixer #(
        .NCH(NCH), .IW(IW), .WOUT(WOUT), .PEAK_HOLD(PH)
    ) dut (
        .CLK96(CLK96), .RESET96_N(RESET96_N), .CEN(CEN),
        .CH_DIN(CH_DIN), .CH_GAIN(CH_GAIN), .CH_EN(CH_EN), .MUTE(MUTE),
        .MIXED(MIXED), .SAMPLE(SAMPLE), .PEAK(PEAK), .BUSY(BUSY)
    );

    always #5 CLK96 = ~CLK96;

    task automatic tick();
        @(posedge CLK96);
        #1;
    endtask

    task automatic check(input string tag, input longint got,
                         input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NCH*IW-1:0] fill(input logic [IW-1:0] v);
        logic [NCH*IW-1:0] d;
        for (int k = 0; k < NCH; k++) d[k*IW +: IW] = v;
        return d;
    endfunction

    function automatic logic [NCH*IW-1:0] rand_din();
        logic [NCH*IW-1:0] d;
        for (int k = 0; k < NCH; k++) d[k*IW +: IW] = IW'($urandom);
        return d;
    endfunction

    function automatic logic [NCH*8-1:0] gains(input logic [7:0] v);
        logic [NCH*8-1:0] g;
        for (int k = 0; k < NCH; k++) g[k*8 +: 8] = v;
        return g;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) g_m[k] = 0;
        since_clip = PH;
    endtask

    // One accepted output sample: ramp gains, sum, scale, clamp, peak.
    task automatic model_step(input logic [NCH*IW-1:0] din,
                              input logic [NCH*8-1:0] gain,
                              input logic [NCH-1:0] en, input logic mute,
                              output logic [WOUT-1:0] e_mix,
                              output bit e_peak);
        longint s;
        longint r;
        longint hi;
        longint lo;
        int t;
        bit clip;
        s  = 0;
        hi = (longint'(1) <<< (WOUT - 1)) - 1;
        lo = -hi - 1;
        for (int k = 0; k < NCH; k++) begin
            t = (mute || !en[k]) ? 0 : int'(gain[k*8 +: 8]);
            if (g_m[k] < t) g_m[k]++;
            else if (g_m[k] > t) g_m[k]--;
            s += longint'($signed(din[k*IW +: IW])) * g_m[k];
        end
        r    = s >>> 4;
        clip = (r > hi) || (r < lo);
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        e_mix = WOUT'(r);
        if (clip) since_clip = 0;
        else if (since_clip < PH) since_clip++;
        e_peak = (since_clip < PH);
    endtask

    // Issue one CEN, scramble inputs once the snapshot is taken, and check
    // latency, result and pulse width. dbl adds a CEN 2 cycles in; late
    // adds a CEN in the OUT cycle; both must be ignored.
    task automatic run_sample(input logic [NCH*IW-1:0] din,
                              input logic [NCH*8-1:0] gain,
                              input logic [NCH-1:0] en, input logic mute,
                              input bit dbl, input bit late);
        logic [WOUT-1:0] e_mix;
        bit e_peak;
        int lat;
        int extra;
        model_step(din, gain, en, mute, e_mix, e_peak);
        CH_DIN  = din;
        CH_GAIN = gain;
        CH_EN   = en;
        MUTE    = mute;
        CEN     = 1'b1;
        tick();
        CEN = 1'b0;
        lat = 1;
        tick();
        lat = 2;
        CH_DIN = rand_din();
        for (int k = 0; k < NCH; k++) CH_GAIN[k*8 +: 8] = 8'($urandom);
        CH_EN = NCH'($urandom);
        MUTE  = 1'($urandom);
        if (dbl) begin
            CEN = 1'b1;
            tick();
            CEN = 1'b0;
            lat++;
        end
        while (!SAMPLE && lat < 4 * NCH + 8) begin
            tick();
            lat++;
        end
        check("latency", lat, NCH + 2);
        check("mixed", MIXED, e_mix);
        check("peak", PEAK, e_peak);
        if (late) CEN = 1'b1;
        tick();
        CEN = 1'b0;
        check("sample_width", SAMPLE, 0);
        check("busy_end", BUSY, 0);
        if (dbl || late) begin
            extra = 0;
            repeat (NCH + 4) begin
                if (SAMPLE) extra++;
                tick();
            end
            check("extra_sample", extra, 0);
        end
    endtask

    initial begin
        logic [NCH*IW-1:0] d;
        logic [NCH*8-1:0] rg;
        n_checks  = 0;
        n_fail    = 0;
        RESET96_N = 1'b0;
        CEN       = 1'b0;
        MUTE      = 1'b0;
        CH_DIN    = '0;
        CH_GAIN   = '0;
        CH_EN     = '0;
        model_reset();
        repeat (2) tick();
        check("rst_mixed", MIXED, 0);
        check("rst_sample", SAMPLE, 0);
        check("rst_peak", PEAK, 0);
        check("rst_busy", BUSY, 0);
        RESET96_N = 1'b1;
        tick();

        for (int i = 0; i < 16; i++)
            run_sample(fill(16'h1000), gains(8'h10), 4'hF, 1'b0, 0, 0);
        check("ramp_final", MIXED, 16'h4000);

        d = '0;
        d[0 +: IW]  = 16'h7FFF;
        d[IW +: IW] = 16'h7FFF;
        run_sample(d, gains(8'h10), 4'hF, 1'b0, 0, 0);
        check("pos_clip_mixed", MIXED, 16'h7FFF);
        check("pos_clip_peak", PEAK, 1);
        for (int i = 0; i < PH; i++)
            run_sample('0, gains(8'h10), 4'hF, 1'b0, 0, 0);
        check("peak_released", PEAK, 0);

        run_sample(fill(16'h8000), gains(8'h10), 4'hF, 1'b0, 0, 0);
        check("neg_clip_mixed", MIXED, 16'h8000);
        check("neg_clip_peak", PEAK, 1);

        d = '0;
        d[0 +: IW] = 16'h0100;
        for (int i = 0; i < 16; i++) begin
            run_sample(d, gains(8'h10), 4'hF, 1'b1, i == 3, i == 5);
            if (i == 0) check("mute_first", MIXED, 16'h00F0);
        end
        check("mute_end", MIXED, 0);
        for (int i = 0; i < 16; i++)
            run_sample(d, gains(8'h10), 4'hF, 1'b0, 0, 0);
        check("unmute_end", MIXED, 16'h0100);

        for (int i = 0; i < 150; i++) begin
            for (int k = 0; k < NCH; k++)
                rg[k*8 +: 8] = 8'($urandom_range(0, 32));
            run_sample(rand_din(), rg, NCH'($urandom),
                       $urandom_range(0, 7) == 0,
                       $urandom_range(0, 7) == 0,
                       $urandom_range(0, 7) == 0);
        end

        for (int i = 0; i < 40; i++)
            run_sample(fill(16'h1000), gains(8'h10), 4'hF, 1'b0, 0, 0);
        check("restore", MIXED, 16'h4000);

        CH_DIN  = fill(16'h1000);
        CH_GAIN = gains(8'h10);
        CH_EN   = 4'hF;
        MUTE    = 1'b0;
        CEN     = 1'b1;
        tick();
        CEN = 1'b0;
        tick();
        tick();
        check("abort_busy_pre", BUSY, 1);
        RESET96_N = 1'b0;
        #1;
        check("abort_mixed", MIXED, 0);
        check("abort_busy", BUSY, 0);
        check("abort_sample", SAMPLE, 0);
        check("abort_peak", PEAK, 0);
        model_reset();
        tick();
        RESET96_N = 1'b1;
        tick();
        run_sample(fill(16'h1000), gains(8'h10), 4'hF, 1'b0, 0, 0);
        check("restart_ramp", MIXED, 16'h0400);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
